// File: rtl/data_path_pkg.sv
// Shared constants for the data_path slice: datapath width, ALU opcodes
// and the sign-extension helper used for the C (immediate) bus source.
package data_path_pkg;

    localparam int DATA_WIDTH = 32;

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_AND  = 5'b00001;
    localparam logic [4:0] OP_OR   = 5'b00010;
    localparam logic [4:0] OP_SUB  = 5'b00011;
    localparam logic [4:0] OP_NOT  = 5'b00100;
    localparam logic [4:0] OP_SHR  = 5'b00101;
    localparam logic [4:0] OP_SHRA = 5'b00110;
    localparam logic [4:0] OP_SHL  = 5'b00111;
    localparam logic [4:0] OP_ROR  = 5'b01000;
    localparam logic [4:0] OP_ROL  = 5'b01001;
    localparam logic [4:0] OP_NEG  = 5'b01010;

    // IR[18:0] immediate widened to a full bus word.
    function automatic logic [DATA_WIDTH-1:0] sext19(
        input logic [DATA_WIDTH-1:0] ir
    );
        return {{(DATA_WIDTH-19){ir[18]}}, ir[18:0]};
    endfunction

endpackage

// File: rtl/data_path_alu.sv
// Combinational ALU: A (from Y) op B (from bus) -> 64-bit {Zhi, Zlo}.
// Ports: a_i, b_i operands; opcode_i operation; inc_pc_i forces B+1; result_o.
module data_path_alu
    import data_path_pkg::*;
(
    input  logic [DATA_WIDTH-1:0]   a_i,
    input  logic [DATA_WIDTH-1:0]   b_i,
    input  logic [4:0]              opcode_i,
    input  logic                    inc_pc_i,
    output logic [2*DATA_WIDTH-1:0] result_o
);

    logic [DATA_WIDTH:0]     sum;
    logic [2*DATA_WIDTH-1:0] rot;
    logic [4:0]              sh;

    assign sh = b_i[4:0];

    always_comb begin
        result_o = '0;
        sum      = '0;
        rot      = '0;
        if (inc_pc_i) begin
            result_o[DATA_WIDTH-1:0] = b_i + 32'd1;
        end else begin
            case (opcode_i)
                OP_ADD: begin
                    // Carry out lands in bit 0 of Zhi.
                    sum = {1'b0, a_i} + {1'b0, b_i};
                    result_o[DATA_WIDTH:0] = sum;
                end
                OP_AND:  result_o[DATA_WIDTH-1:0] = a_i & b_i;
                OP_OR:   result_o[DATA_WIDTH-1:0] = a_i | b_i;
                OP_SUB:  result_o[DATA_WIDTH-1:0] = a_i - b_i;
                OP_NOT:  result_o[DATA_WIDTH-1:0] = ~b_i;
                OP_SHR:  result_o[DATA_WIDTH-1:0] = a_i >> sh;
                OP_SHRA: result_o[DATA_WIDTH-1:0] = $unsigned($signed(a_i) >>> sh);
                OP_SHL:  result_o[DATA_WIDTH-1:0] = a_i << sh;
                OP_ROR: begin
                    // Shifting a doubled copy gives the rotate in the low half.
                    rot = {a_i, a_i} >> sh;
                    result_o[DATA_WIDTH-1:0] = rot[DATA_WIDTH-1:0];
                end
                OP_ROL: begin
                    rot = {a_i, a_i} << sh;
                    result_o[DATA_WIDTH-1:0] = rot[2*DATA_WIDTH-1:DATA_WIDTH];
                end
                OP_NEG:  result_o[DATA_WIDTH-1:0] = 32'd0 - b_i;
                default: result_o = '0;
            endcase
        end
    end

endmodule

// File: rtl/data_path.sv
// Single-bus CPU datapath: 16 GPRs, PC, IR, MAR, MDR, HI, LO, Y, Z, I/O ports.
// Ports: *in load enables, *out bus selects, memory/input data, debug taps.
module data_path
    import data_path_pkg::*;
(
    input  logic        clock,
    input  logic        clear,
    input  logic        R0in,  input logic R1in,  input logic R2in,  input logic R3in,
    input  logic        R4in,  input logic R5in,  input logic R6in,  input logic R7in,
    input  logic        R8in,  input logic R9in,  input logic R10in, input logic R11in,
    input  logic        R12in, input logic R13in, input logic R14in, input logic R15in,
    input  logic        IRin,
    input  logic        PCin,
    input  logic        RYin,
    input  logic        RZin,
    input  logic        MARin,
    input  logic        MDRin,
    input  logic        HIin,
    input  logic        LOin,
    input  logic        Outport_in,
    input  logic        Inport_in,
    input  logic        IncPC,
    input  logic        R0out,  input logic R1out,  input logic R2out,  input logic R3out,
    input  logic        R4out,  input logic R5out,  input logic R6out,  input logic R7out,
    input  logic        R8out,  input logic R9out,  input logic R10out, input logic R11out,
    input  logic        R12out, input logic R13out, input logic R14out, input logic R15out,
    input  logic        HIout,
    input  logic        LOout,
    input  logic        Zhi_out,
    input  logic        Zlo_out,
    input  logic        PCout,
    input  logic        MDRout,
    input  logic        Inport_out,
    input  logic        Cout,
    input  logic        Mem_read,
    input  logic [31:0] MDR_Mem_lines,
    input  logic [31:0] Inport_data_in,
    input  logic [4:0]  opcode,
    output logic [31:0] MAR_to_chip,
    output logic [31:0] Outport_data_out,
    output logic [31:0] reg1,
    output logic [31:0] reg2,
    output logic [31:0] reg3,
    output logic [31:0] reg4,
    output logic [31:0] reg5,
    output logic [31:0] reg6,
    output logic [31:0] reg7,
    output logic [31:0] regMDR,
    output logic [31:0] PC_VALUE,
    output logic [31:0] HI_VALUE,
    output logic [31:0] LO_VALUE,
    output logic [31:0] IR_VALUE,
    output logic [31:0] BusMuxOut_out
);

    logic [15:0]           rin;
    logic [15:0]           rout;
    logic [DATA_WIDTH-1:0] r_q [16];
    logic [DATA_WIDTH-1:0] r_d [16];

    logic [DATA_WIDTH-1:0] pc_q, ir_q, mar_q, mdr_q, hi_q, lo_q, y_q;
    logic [DATA_WIDTH-1:0] inp_q, outp_q;
    logic [DATA_WIDTH-1:0] pc_d, ir_d, mar_d, mdr_d, hi_d, lo_d, y_d;
    logic [DATA_WIDTH-1:0] inp_d, outp_d;
    logic [2*DATA_WIDTH-1:0] z_q, z_d, alu_res;

    logic [DATA_WIDTH-1:0] bus;
    logic                  hit;

    assign rin  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                   R7in,  R6in,  R5in,  R4in,  R3in,  R2in,  R1in, R0in};
    assign rout = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                   R7out,  R6out,  R5out,  R4out,  R3out,  R2out,  R1out, R0out};

    // Priority bus encoder: lowest-numbered GPR first, then special sources.
    always_comb begin
        bus = '0;
        hit = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (!hit && rout[i]) begin
                bus = r_q[i];
                hit = 1'b1;
            end
        end
        if (!hit) begin
            if (HIout)           bus = hi_q;
            else if (LOout)      bus = lo_q;
            else if (Zhi_out)    bus = z_q[2*DATA_WIDTH-1:DATA_WIDTH];
            else if (Zlo_out)    bus = z_q[DATA_WIDTH-1:0];
            else if (PCout)      bus = pc_q;
            else if (MDRout)     bus = mdr_q;
            else if (Inport_out) bus = inp_q;
            else if (Cout)       bus = sext19(ir_q);
            else                 bus = '0;
        end
    end

    data_path_alu u_alu (
        .a_i      (y_q),
        .b_i      (bus),
        .opcode_i (opcode),
        .inc_pc_i (IncPC),
        .result_o (alu_res)
    );

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            r_d[i] = rin[i] ? bus : r_q[i];
        end
    end

    assign pc_d   = PCin       ? bus : pc_q;
    assign ir_d   = IRin       ? bus : ir_q;
    assign mar_d  = MARin      ? bus : mar_q;
    assign hi_d   = HIin       ? bus : hi_q;
    assign lo_d   = LOin       ? bus : lo_q;
    assign y_d    = RYin       ? bus : y_q;
    assign outp_d = Outport_in ? bus : outp_q;
    assign inp_d  = Inport_in  ? Inport_data_in : inp_q;
    assign z_d    = RZin       ? alu_res : z_q;
    assign mdr_d  = !MDRin     ? mdr_q :
                    Mem_read   ? MDR_Mem_lines : bus;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            for (int i = 0; i < 16; i++) r_q[i] <= '0;
            pc_q   <= '0;
            ir_q   <= '0;
            mar_q  <= '0;
            mdr_q  <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            y_q    <= '0;
            z_q    <= '0;
            inp_q  <= '0;
            outp_q <= '0;
        end else begin
            for (int i = 0; i < 16; i++) r_q[i] <= r_d[i];
            pc_q   <= pc_d;
            ir_q   <= ir_d;
            mar_q  <= mar_d;
            mdr_q  <= mdr_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            y_q    <= y_d;
            z_q    <= z_d;
            inp_q  <= inp_d;
            outp_q <= outp_d;
        end
    end

    assign MAR_to_chip      = mar_q;
    assign Outport_data_out = outp_q;
    assign reg1             = r_q[1];
    assign reg2             = r_q[2];
    assign reg3             = r_q[3];
    assign reg4             = r_q[4];
    assign reg5             = r_q[5];
    assign reg6             = r_q[6];
    assign reg7             = r_q[7];
    assign regMDR           = mdr_q;
    assign PC_VALUE         = pc_q;
    assign HI_VALUE         = hi_q;
    assign LO_VALUE         = lo_q;
    assign IR_VALUE         = ir_q;
    assign BusMuxOut_out    = bus;

endmodule

// File: tb/tb_data_path.sv
// Directed self-checking bench for data_path.
// Each task drives one scenario and checks its own expected values.
module tb_data_path;

    logic        clock, clear;
    logic [15:0] rin, rout;
    logic        IRin, PCin, RYin, RZin, MARin, MDRin, HIin, LOin;
    logic        Outport_in, Inport_in, IncPC;
    logic        HIout, LOout, Zhi_out, Zlo_out, PCout, MDRout, Inport_out, Cout;
    logic        Mem_read;
    logic [31:0] MDR_Mem_lines, Inport_data_in;
    logic [4:0]  opcode;
    logic [31:0] MAR_to_chip, Outport_data_out;
    logic [31:0] reg1, reg2, reg3, reg4, reg5, reg6, reg7;
    logic [31:0] regMDR, PC_VALUE, HI_VALUE, LO_VALUE, IR_VALUE, BusMuxOut_out;

    int pass_cnt = 0;
    int total    = 0;

    data_path dut (
        .clock(clock), .clear(clear),
        .R0in(rin[0]),   .R1in(rin[1]),   .R2in(rin[2]),   .R3in(rin[3]),
        .R4in(rin[4]),   .R5in(rin[5]),   .R6in(rin[6]),   .R7in(rin[7]),
        .R8in(rin[8]),   .R9in(rin[9]),   .R10in(rin[10]), .R11in(rin[11]),
        .R12in(rin[12]), .R13in(rin[13]), .R14in(rin[14]), .R15in(rin[15]),
        .IRin(IRin), .PCin(PCin), .RYin(RYin), .RZin(RZin),
        .MARin(MARin), .MDRin(MDRin), .HIin(HIin), .LOin(LOin),
        .Outport_in(Outport_in), .Inport_in(Inport_in), .IncPC(IncPC),
        .R0out(rout[0]),   .R1out(rout[1]),   .R2out(rout[2]),   .R3out(rout[3]),
        .R4out(rout[4]),   .R5out(rout[5]),   .R6out(rout[6]),   .R7out(rout[7]),
        .R8out(rout[8]),   .R9out(rout[9]),   .R10out(rout[10]), .R11out(rout[11]),
        .R12out(rout[12]), .R13out(rout[13]), .R14out(rout[14]), .R15out(rout[15]),
        .HIout(HIout), .LOout(LOout), .Zhi_out(Zhi_out), .Zlo_out(Zlo_out),
        .PCout(PCout), .MDRout(MDRout), .Inport_out(Inport_out), .Cout(Cout),
        .Mem_read(Mem_read), .MDR_Mem_lines(MDR_Mem_lines),
        .Inport_data_in(Inport_data_in), .opcode(opcode),
        .MAR_to_chip(MAR_to_chip), .Outport_data_out(Outport_data_out),
        .reg1(reg1), .reg2(reg2), .reg3(reg3), .reg4(reg4),
        .reg5(reg5), .reg6(reg6), .reg7(reg7),
        .regMDR(regMDR), .PC_VALUE(PC_VALUE), .HI_VALUE(HI_VALUE),
        .LO_VALUE(LO_VALUE), .IR_VALUE(IR_VALUE), .BusMuxOut_out(BusMuxOut_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic idle();
        rin = '0; rout = '0;
        IRin = 0; PCin = 0; RYin = 0; RZin = 0; MARin = 0; MDRin = 0;
        HIin = 0; LOin = 0; Outport_in = 0; Inport_in = 0; IncPC = 0;
        HIout = 0; LOout = 0; Zhi_out = 0; Zlo_out = 0; PCout = 0;
        MDRout = 0; Inport_out = 0; Cout = 0; Mem_read = 0;
        opcode = 5'b0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Put a constant into a GPR through the input port.
    task automatic load_reg(input int idx, input logic [31:0] val);
        idle();
        Inport_data_in = val;
        Inport_in = 1;
        tick();
        idle();
        Inport_out = 1;
        rin[idx] = 1;
        tick();
        idle();
    endtask

    // Y <= R[ya]; Z <= Y op R[bi]; R[dst] <= Zlo.
    task automatic alu_op(input int ya, input int bi,
                          input logic [4:0] op, input int dst);
        idle();
        rout[ya] = 1; RYin = 1;
        tick();
        idle();
        rout[bi] = 1; opcode = op; RZin = 1;
        tick();
        idle();
        Zlo_out = 1; rin[dst] = 1;
        tick();
        idle();
    endtask

    task automatic test_reset();
        idle();
        MDR_Mem_lines = '0;
        Inport_data_in = '0;
        clear = 0;
        #3;
        total++;
        if ({reg1, reg2, PC_VALUE, IR_VALUE, MAR_to_chip, regMDR} !== '0)
            $display("FAIL reset_taps got %h %h %h %h %h %h want 0",
                     reg1, reg2, PC_VALUE, IR_VALUE, MAR_to_chip, regMDR);
        else pass_cnt++;
        total++;
        if (BusMuxOut_out !== 32'h0)
            $display("FAIL reset_bus got %h want 0", BusMuxOut_out);
        else pass_cnt++;
        @(negedge clock);
        clear = 1;
        tick();
    endtask

    task automatic test_load();
        idle();
        MDR_Mem_lines = 32'h10; Mem_read = 1; MDRin = 1;
        tick();
        total++;
        if (regMDR !== 32'h10)
            $display("FAIL load_mdr got %h want 00000010", regMDR);
        else pass_cnt++;
        idle();
        MDRout = 1; rin[2] = 1; PCin = 1;
        tick();
        idle();
        total++;
        if (reg2 !== 32'h10 || PC_VALUE !== 32'h10)
            $display("FAIL load_r2_pc got %h %h want 00000010", reg2, PC_VALUE);
        else pass_cnt++;
    endtask

    task automatic test_fetch();
        idle();
        PCout = 1; IncPC = 1; MARin = 1; RZin = 1;
        tick();
        idle();
        total++;
        if (MAR_to_chip !== 32'h10)
            $display("FAIL fetch_mar got %h want 00000010", MAR_to_chip);
        else pass_cnt++;
        Zlo_out = 1;
        #1;
        total++;
        if (BusMuxOut_out !== 32'h11)
            $display("FAIL fetch_zlo got %h want 00000011", BusMuxOut_out);
        else pass_cnt++;
        PCin = 1;
        tick();
        idle();
        total++;
        if (PC_VALUE !== 32'h11)
            $display("FAIL fetch_pc got %h want 00000011", PC_VALUE);
        else pass_cnt++;
        MDR_Mem_lines = 32'h28918000; Mem_read = 1; MDRin = 1;
        tick();
        idle();
        MDRout = 1; IRin = 1;
        tick();
        idle();
        total++;
        if (IR_VALUE !== 32'h28918000)
            $display("FAIL fetch_ir got %h want 28918000", IR_VALUE);
        else pass_cnt++;
    endtask

    task automatic test_shifts();
        load_reg(1, 32'hDEADBEEF);
        load_reg(2, 32'h10);
        load_reg(3, 32'h14);
        alu_op(2, 3, 5'b00101, 1);
        total++;
        if (reg1 !== 32'h0)
            $display("FAIL shr_small got %h want 00000000", reg1);
        else pass_cnt++;
        load_reg(1, 32'hDEADBEEF);
        alu_op(2, 3, 5'b00110, 1);
        total++;
        if (reg1 !== 32'h0)
            $display("FAIL shra_small got %h want 00000000", reg1);
        else pass_cnt++;
        load_reg(4, 32'h80000000);
        load_reg(5, 32'h4);
        alu_op(4, 5, 5'b00110, 1);
        total++;
        if (reg1 !== 32'hF8000000)
            $display("FAIL shra_neg got %h want f8000000", reg1);
        else pass_cnt++;
        alu_op(4, 5, 5'b00101, 1);
        total++;
        if (reg1 !== 32'h08000000)
            $display("FAIL shr_neg got %h want 08000000", reg1);
        else pass_cnt++;
    endtask

    task automatic test_shl();
        alu_op(2, 3, 5'b00111, 1);
        total++;
        if (reg1 !== 32'h01000000)
            $display("FAIL shl got %h want 01000000", reg1);
        else pass_cnt++;
    endtask

    task automatic test_add_sub();
        load_reg(6, 32'hFFFFFFFF);
        load_reg(7, 32'h1);
        load_reg(1, 32'h5);
        alu_op(6, 7, 5'b00000, 1);
        total++;
        if (reg1 !== 32'h0)
            $display("FAIL add_lo got %h want 00000000", reg1);
        else pass_cnt++;
        Zhi_out = 1;
        #1;
        total++;
        if (BusMuxOut_out !== 32'h1)
            $display("FAIL add_carry got %h want 00000001", BusMuxOut_out);
        else pass_cnt++;
        idle();
        alu_op(0, 7, 5'b00011, 1);
        total++;
        if (reg1 !== 32'hFFFFFFFF)
            $display("FAIL sub_wrap got %h want ffffffff", reg1);
        else pass_cnt++;
        Zhi_out = 1;
        #1;
        total++;
        if (BusMuxOut_out !== 32'h0)
            $display("FAIL sub_hi got %h want 00000000", BusMuxOut_out);
        else pass_cnt++;
        idle();
    endtask

    task automatic test_logic_rot();
        load_reg(6, 32'h12345678);
        load_reg(5, 32'h24);
        alu_op(6, 3, 5'b00001, 1);
        total++;
        if (reg1 !== 32'h10)
            $display("FAIL and got %h want 00000010", reg1);
        else pass_cnt++;
        alu_op(6, 3, 5'b00010, 1);
        total++;
        if (reg1 !== 32'h1234567C)
            $display("FAIL or got %h want 1234567c", reg1);
        else pass_cnt++;
        alu_op(6, 3, 5'b00100, 1);
        total++;
        if (reg1 !== 32'hFFFFFFEB)
            $display("FAIL not got %h want ffffffeb", reg1);
        else pass_cnt++;
        alu_op(6, 3, 5'b01010, 1);
        total++;
        if (reg1 !== 32'hFFFFFFEC)
            $display("FAIL neg got %h want ffffffec", reg1);
        else pass_cnt++;
        alu_op(6, 5, 5'b01000, 1);
        total++;
        if (reg1 !== 32'h81234567)
            $display("FAIL ror got %h want 81234567", reg1);
        else pass_cnt++;
        alu_op(6, 5, 5'b01001, 1);
        total++;
        if (reg1 !== 32'h23456781)
            $display("FAIL rol got %h want 23456781", reg1);
        else pass_cnt++;
        alu_op(6, 0, 5'b01000, 1);
        total++;
        if (reg1 !== 32'h12345678)
            $display("FAIL ror_zero got %h want 12345678", reg1);
        else pass_cnt++;
        alu_op(6, 3, 5'b01011, 1);
        total++;
        if (reg1 !== 32'h0)
            $display("FAIL bad_op got %h want 00000000", reg1);
        else pass_cnt++;
    endtask

    task automatic test_bus_priority();
        idle();
        rout[2] = 1; rout[3] = 1;
        #1;
        total++;
        if (BusMuxOut_out !== 32'h10)
            $display("FAIL prio_gpr got %h want 00000010", BusMuxOut_out);
        else pass_cnt++;
        idle();
        rout[6] = 1; HIin = 1; Outport_in = 1;
        tick();
        idle();
        total++;
        if (HI_VALUE !== 32'h12345678 || Outport_data_out !== 32'h12345678)
            $display("FAIL hi_outport got %h %h want 12345678",
                     HI_VALUE, Outport_data_out);
        else pass_cnt++;
        HIout = 1; rout[3] = 1;
        #1;
        total++;
        if (BusMuxOut_out !== 32'h14)
            $display("FAIL prio_gpr_hi got %h want 00000014", BusMuxOut_out);
        else pass_cnt++;
        idle();
        HIout = 1; PCout = 1;
        #1;
        total++;
        if (BusMuxOut_out !== 32'h12345678)
            $display("FAIL prio_hi_pc got %h want 12345678", BusMuxOut_out);
        else pass_cnt++;
        idle();
        load_reg(7, 32'h00040001);
        rout[7] = 1; IRin = 1;
        tick();
        idle();
        Cout = 1;
        #1;
        total++;
        if (BusMuxOut_out !== 32'hFFFC0001)
            $display("FAIL c_sext got %h want fffc0001", BusMuxOut_out);
        else pass_cnt++;
        idle();
        #1;
        total++;
        if (BusMuxOut_out !== 32'h0)
            $display("FAIL bus_none got %h want 00000000", BusMuxOut_out);
        else pass_cnt++;
        rout[3] = 1; opcode = 5'b00000; IncPC = 1; RZin = 1; rin[3] = 1;
        tick();
        idle();
        Zlo_out = 1; rin[3] = 1;
        tick();
        idle();
        total++;
        if (reg3 !== 32'h15)
            $display("FAIL self_load got %h want 00000015", reg3);
        else pass_cnt++;
    endtask

    task automatic test_mid_reset();
        idle();
        Inport_data_in = 32'h55;
        Inport_in = 1;
        tick();
        idle();
        Inport_out = 1; rin[1] = 1;
        #2;
        clear = 0;
        #1;
        total++;
        if ({reg1, reg2, reg3, reg4, reg5, reg6, reg7} !== '0)
            $display("FAIL midreset_regs got %h %h %h %h %h %h %h want 0",
                     reg1, reg2, reg3, reg4, reg5, reg6, reg7);
        else pass_cnt++;
        total++;
        if ({PC_VALUE, IR_VALUE, MAR_to_chip} !== '0)
            $display("FAIL midreset_pc_ir_mar got %h %h %h want 0",
                     PC_VALUE, IR_VALUE, MAR_to_chip);
        else pass_cnt++;
        @(negedge clock);
        clear = 1;
        tick();
        total++;
        if (reg1 !== 32'h0)
            $display("FAIL midreset_resume got %h want 00000000", reg1);
        else pass_cnt++;
        idle();
        load_reg(2, 32'hA5);
        total++;
        if (reg2 !== 32'hA5)
            $display("FAIL after_reset got %h want 000000a5", reg2);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_load();
        test_fetch();
        test_shifts();
        test_shl();
        test_add_sub();
        test_logic_rot();
        test_bus_priority();
        test_mid_reset();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/data_path.md
DATA_PATH -- requirements
Module: data_path

Interface
REQ-001 clock  in  1  sole clock; all registers update on rising edge.
REQ-002 clear  in  1  reset; asynchronous, active-low (0 = reset asserted).
REQ-003 R0in..R15in, IRin, PCin, RYin, RZin, MARin, MDRin, HIin, LOin, Outport_in, Inport_in  in  1 each  register load enables.
REQ-004 IncPC  in  1  ALU forces Z = bus + 1.
REQ-005 R0out..R15out, HIout, LOout, Zhi_out, Zlo_out, PCout, MDRout, Inport_out, Cout  in  1 each  bus-drive selects.
REQ-006 Mem_read  in  1  MDR input mux select (1 = memory).
REQ-007 MDR_Mem_lines  in  32  memory read data.
REQ-008 Inport_data_in  in  32  external input port data.
REQ-009 opcode  in  5  ALU operation.
REQ-010 MAR_to_chip  out  32  MAR contents.
REQ-011 Outport_data_out  out  32  output port register.
REQ-012 reg1..reg7, regMDR, PC_VALUE, HI_VALUE, LO_VALUE, IR_VALUE  out  32 each  debug taps of R1..R7, MDR, PC, HI, LO, IR.
REQ-013 BusMuxOut_out  out  32  current bus value.

Function
REQ-014 Bus is combinational: exactly the selected source drives it; if several are selected, priority R0..R15, HI, LO, Zhi, Zlo, PC, MDR, Inport, C (lowest index wins); none selected -> 0.
REQ-015 C source = IR[18:0] sign-extended to 32 bits.
REQ-016 Each 32-bit register (R0..R15, PC, IR, MAR, HI, LO, Y, Inport, Outport) loads bus on edge when its enable is 1, else holds; Inport loads Inport_data_in.
REQ-017 MDR loads on MDRin: data = MDR_Mem_lines if Mem_read=1, else bus.
REQ-018 ALU operands: A = Y, B = bus; result 64 bits, captured into Z (Zhi:Zlo) when RZin=1.
REQ-019 IncPC=1 overrides opcode: Z = {0, B+1}.
REQ-020 Opcodes (Zhi=0 unless noted): 00000 ADD A+B, Zhi = carry; 00001 AND; 00010 OR; 00011 SUB A-B; 00100 NOT B; 00101 SHR logical A>>B[4:0]; 00110 SHRA arithmetic A>>>B[4:0]; 00111 SHL A<<B[4:0]; 01000 ROR A by B[4:0]; 01001 ROL A by B[4:0]; 01010 NEG -B; others Z = 0.
REQ-021 Shift/rotate amount uses B[4:0] only; amount 0 returns A unchanged.
REQ-022 Arithmetic wraps modulo 2^32 in Zlo.
REQ-023 Simultaneous enable of a register as bus source and destination: register loads value present on bus before edge.
REQ-024 No pipelining: register write visible one edge after enable; outputs are direct register taps.

Reset
REQ-025 clear=0 asynchronously zeroes every register (R0..R15, PC, IR, MAR, MDR, HI, LO, Y, Z, Inport, Outport); all taps read 0 while held.
REQ-026 Reset mid-operation discards any pending load; operation resumes from zeroed state on first edge after clear=1.

Structure
REQ-027 Shared package holds opcode constants and DATA_WIDTH=32.
REQ-028 One sub-module natural: alu (combinational, A, B, opcode, IncPC -> 64-bit result); registers and bus encoder inline.

Verification
REQ-029 Load: MDR_Mem_lines=0x10, Mem_read+MDRin one edge, then MDRout+R2in+PCin -> reg2=0x10, PC_VALUE=0x10.
REQ-030 Fetch: PC=0x10, PCout+IncPC+MARin+RZin -> MAR_to_chip=0x10, Zlo=0x11; Zlo_out+PCin -> PC_VALUE=0x11; memory 0x28918000 via MDR -> IR_VALUE=0x28918000.
REQ-031 SHR/SHRA: Y=0x10 (R2), B=0x14 (R3), opcode 00101 or 00110 -> Zlo_out into R1 gives reg1=0x00000000; Y=0x80000000, B=4, SHRA -> 0xF8000000, SHR -> 0x08000000.
REQ-032 SHL: Y=0x10, B=0x14, opcode 00111 -> reg1=0x01000000.
REQ-033 ADD overflow: Y=0xFFFFFFFF, B=1 -> Zlo=0, Zhi=1; SUB Y=0, B=1 -> Zlo=0xFFFFFFFF.
REQ-034 Reset: clear=0 mid-sequence with R1in asserted -> reg1..reg7, PC_VALUE, IR_VALUE, MAR_to_chip all 0 immediately, no edge required.
